// File: rtl/divider.sv
// IEEE-754 single-precision divider z = a / b with stb/ack operand and result handshakes.
// Iterative restoring division (one quotient bit per two cycles), round-to-nearest-even.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, DIVIDE_3, NORMALISE_1, NORMALISE_2,
    ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_SPECIAL = 10'sd128;
  localparam logic signed [9:0] E_ZERO    = -10'sd127;
  localparam logic signed [9:0] E_DMIN    = -10'sd126;
  localparam logic signed [9:0] E_MAX     = 10'sd127;
  localparam logic [31:0]       QNAN      = 32'hFFC00000;

  state_t state_q, state_d;

  logic [31:0]       a, b, z;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic              guard, round_bit, sticky;
  logic [50:0]       quotient, divisor, dividend, remainder;
  logic [5:0]        count;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special;
  logic [31:0] special_z;
  logic        last_iter;

  // Special operand classification; first matching rule wins.
  always_comb begin
    a_nan     = (a_e == E_SPECIAL) && (a_m != '0);
    b_nan     = (b_e == E_SPECIAL) && (b_m != '0);
    a_inf     = (a_e == E_SPECIAL) && (a_m == '0);
    b_inf     = (b_e == E_SPECIAL) && (b_m == '0);
    a_zero    = (a_e == E_ZERO) && (a_m == '0);
    b_zero    = (b_e == E_ZERO) && (b_m == '0);
    special   = 1'b1;
    special_z = QNAN;
    if (a_nan || b_nan)      special_z = QNAN;
    else if (a_inf && b_inf) special_z = QNAN;
    else if (a_inf)          special_z = {a_s ^ b_s, 8'hFF, 23'd0};
    else if (b_inf)          special_z = {a_s ^ b_s, 31'd0};
    else if (b_zero && a_zero) special_z = QNAN;
    else if (b_zero)         special_z = {a_s ^ b_s, 8'hFF, 23'd0};
    else if (a_zero)         special_z = {a_s ^ b_s, 31'd0};
    else                     special = 1'b0;
  end

  // 50 iterations: quotient ends as floor(a_m * 2^26 / b_m), leading one at bit 26 or 25.
  assign last_iter = (count + 6'd1) == 6'd50;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= GET_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GET_A:         if (input_a_ack && input_a_stb) state_d = GET_B;
      GET_B:         if (input_b_ack && input_b_stb) state_d = UNPACK;
      UNPACK:        state_d = SPECIAL_CASES;
      SPECIAL_CASES: state_d = special ? PUT_Z : NORMALISE_A;
      NORMALISE_A:   if (a_m[23]) state_d = NORMALISE_B;
      NORMALISE_B:   if (b_m[23]) state_d = DIVIDE_0;
      DIVIDE_0:      state_d = DIVIDE_1;
      DIVIDE_1:      state_d = DIVIDE_2;
      DIVIDE_2:      state_d = last_iter ? DIVIDE_3 : DIVIDE_1;
      DIVIDE_3:      state_d = NORMALISE_1;
      NORMALISE_1:   if (z_m[23]) state_d = NORMALISE_2;
      NORMALISE_2:   if (!(z_e < E_DMIN)) state_d = ROUND;
      ROUND:         state_d = PACK;
      PACK:          state_d = PUT_Z;
      PUT_Z:         if (output_z_stb && output_z_ack) state_d = GET_A;
      default:       state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a         <= '0;
      b         <= '0;
      z         <= '0;
      a_m       <= '0;
      b_m       <= '0;
      z_m       <= '0;
      a_e       <= '0;
      b_e       <= '0;
      z_e       <= '0;
      a_s       <= 1'b0;
      b_s       <= 1'b0;
      z_s       <= 1'b0;
      guard     <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
      quotient  <= '0;
      divisor   <= '0;
      dividend  <= '0;
      remainder <= '0;
      count     <= '0;
    end else begin
      unique case (state_q)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
          end
        end
        GET_B: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
          end
        end
        UNPACK: begin
          a_m <= {1'b0, a[22:0]};
          b_m <= {1'b0, b[22:0]};
          a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
          a_s <= a[31];
          b_s <= b[31];
        end
        SPECIAL_CASES: begin
          if (special) begin
            z <= special_z;
          end else begin
            if (a_e == E_ZERO) a_e <= E_DMIN;
            else               a_m[23] <= 1'b1;
            if (b_e == E_ZERO) b_e <= E_DMIN;
            else               b_m[23] <= 1'b1;
          end
        end
        NORMALISE_A: begin
          if (!a_m[23]) begin
            a_m <= a_m << 1;
            a_e <= a_e - 10'sd1;
          end
        end
        NORMALISE_B: begin
          if (!b_m[23]) begin
            b_m <= b_m << 1;
            b_e <= b_e - 10'sd1;
          end
        end
        DIVIDE_0: begin
          z_s       <= a_s ^ b_s;
          z_e       <= a_e - b_e;
          dividend  <= {a_m, 27'd0};
          divisor   <= {27'd0, b_m};
          quotient  <= '0;
          remainder <= '0;
          count     <= '0;
        end
        DIVIDE_1: begin
          quotient  <= {quotient[49:0], 1'b0};
          remainder <= {remainder[49:0], dividend[50]};
          dividend  <= {dividend[49:0], 1'b0};
        end
        DIVIDE_2: begin
          if (remainder >= divisor) begin
            quotient[0] <= 1'b1;
            remainder   <= remainder - divisor;
          end
          count <= count + 6'd1;
        end
        DIVIDE_3: begin
          z_m       <= quotient[26:3];
          guard     <= quotient[2];
          round_bit <= quotient[1];
          sticky    <= quotient[0] | (remainder != '0);
        end
        NORMALISE_1: begin
          if (!z_m[23]) begin
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end
        end
        NORMALISE_2: begin
          if (z_e < E_DMIN) begin
            z_e       <= z_e + 10'sd1;
            z_m       <= z_m >> 1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end
        end
        ROUND: begin
          if (guard && (round_bit | sticky | z_m[0])) begin
            z_m <= z_m + 24'd1;
            if (z_m == 24'hFFFFFF) z_e <= z_e + 10'sd1;
          end
        end
        PACK: begin
          z[31] <= z_s;
          if (z_e > E_MAX) begin
            z[30:23] <= 8'hFF;
            z[22:0]  <= '0;
          end else begin
            z[22:0]  <= z_m[22:0];
            z[30:23] <= ((z_e == E_DMIN) && !z_m[23]) ? 8'd0 : z_e[7:0] + 8'd127;
          end
        end
        PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
